// File: rtl/seg7_blink_if.sv
// Purpose : digit-load handshake, blink control and 7-segment outputs of seg7_blink_driver.
// Ports   : master = stimulus side (drives load/blink controls); slave = driver side.
// Latency/backpressure: no logic here; in_ready stalls loads whenever the driver is blinking.
interface seg7_blink_if;
  // Digit load (valid/ready)
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  // Blink control
  logic       blink_start;
  logic [3:0] blink_num;
  logic       blink_stop;
  // Display outputs toward the downstream 2:1 mux
  logic [6:0] seg_data;
  logic [6:0] seg_blank;
  logic       sel;
  // Status
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_data, blink_start, blink_num, blink_stop,
    input  in_ready, seg_data, seg_blank, sel, busy, done
  );

  modport slave (
    input  in_valid, in_data, blink_start, blink_num, blink_stop,
    output in_ready, seg_data, seg_blank, sel, busy, done
  );
endinterface

// File: rtl/seg7_blink_driver.sv
// Purpose : holds one hex digit, decodes it to a 7-segment pattern and blinks it by steering
//           a downstream 2:1 mux between seg_data (sel=0) and the constant seg_blank (sel=1).
// Latency : seg_data follows an accepted digit one cycle later; sel/busy/done are registered.
// Backpressure: in_ready is high only in IDLE, so digit loads stall for the whole blink sequence.
//
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : seg7_blink_if.slave
//                in_valid/in_ready/in_data     - hex digit load handshake
//                blink_start/blink_num/blink_stop - start N blinks (0 = endless) / abort
//                seg_data/seg_blank/sel        - decoded digit, blank pattern, mux select
//                busy/done                     - blinking in progress / end-of-sequence pulse
module seg7_blink_driver #(
  parameter int unsigned HALF_PERIOD = 25000000, // cycles per ON or OFF half-phase (>= 2)
  parameter int unsigned CNT_W       = 25,       // phase counter width, 2^CNT_W >= HALF_PERIOD
  parameter logic [6:0]  BLANK_PAT   = 7'h00     // pattern shown during the OFF half-phase
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_blink_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(HALF_PERIOD - 1);

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] phase_q,  phase_d;
  logic [3:0]       remain_q, remain_d;
  logic [3:0]       digit_q,  digit_d;
  logic [6:0]       seg_q,    seg_d;
  logic             sel_q,    sel_d;
  logic             done_q,   done_d;

  logic load;
  logic phase_end;
  logic stop_req;

  // Active-high segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] pat;
    case (hex)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // in_ready is a pure decode of the state register, so it reads 1 throughout reset too.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign load          = bus.in_valid && bus.in_ready;
  assign phase_end     = (phase_q == TERM_CNT);
  assign stop_req      = bus.blink_stop;

  assign bus.seg_data  = seg_q;
  assign bus.seg_blank = BLANK_PAT;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    digit_d  = load ? bus.in_data : digit_q;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous stop cancels the start; a lone stop in IDLE does nothing.
        if (bus.blink_start && !stop_req) begin
          remain_d = bus.blink_num;
          phase_d  = '0;
          state_d  = ST_ON;
        end
      end

      ST_ON: begin
        if (stop_req) begin
          state_d  = ST_IDLE;
          phase_d  = '0;
          remain_d = 4'd0;
          done_d   = 1'b1;
        end else if (phase_end) begin
          state_d = ST_OFF;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_OFF: begin
        if (stop_req) begin
          state_d  = ST_IDLE;
          phase_d  = '0;
          remain_d = 4'd0;
          done_d   = 1'b1;
        end else if (phase_end) begin
          phase_d = '0;
          // remain_q can only be zero here in endless mode: a finite count leaves
          // through IDLE when it reaches zero. Holding it avoids wrapping to 15.
          if (remain_q == 4'd0) begin
            state_d = ST_ON;
          end else begin
            remain_d = remain_q - 4'd1;
            if (remain_q == 4'd1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_ON;
            end
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        phase_d  = '0;
        remain_d = 4'd0;
      end
    endcase

    // sel is registered from the next state so it lines up with state_q exactly.
    sel_d = (state_d == ST_OFF);
    seg_d = hex_to_seg(digit_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      remain_q <= 4'd0;
      digit_q  <= 4'd0;
      seg_q    <= 7'h3F;
      sel_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      digit_q  <= digit_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_seg7_blink_driver.sv
// Purpose : directed + randomized bench for seg7_blink_driver with HALF_PERIOD = 4.
// Timing  : inputs change and outputs are sampled on the falling clock edge.
// Model   : cycle k after a start shows sel = (k / HP) % 2 until 2*HP*N cycles, then done.
module tb_seg7_blink_driver;

  localparam int HP = 4;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_blink_if bus ();

  seg7_blink_driver #(
    .HALF_PERIOD (HP),
    .CNT_W       (3),
    .BLANK_PAT   (7'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues a start with blink_num = num at the current falling edge and follows the whole
  // sequence against the arithmetic model. stop_at/restart_at < 0 disable those pulses.
  // pend_en raises a digit load during the blink that must only land once IDLE returns.
  task automatic blink_run(input logic [3:0] num, input int stop_at, input int restart_at,
                           input logic [6:0] seg_exp, input logic pend_en,
                           input logic [3:0] pend_dig);
    int   total;
    logic finished;
    total    = 2 * HP * int'(num);
    finished = 1'b0;
    bus.blink_num   = num;
    bus.blink_start = 1'b1;
    @(negedge clk);
    bus.blink_start = 1'b0;
    bus.in_valid    = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (k == stop_at) begin
        bus.blink_start = 1'b0;
        bus.blink_stop  = 1'b1;
        @(negedge clk);
        bus.blink_stop  = 1'b0;
        finished = 1'b1;
        break;
      end
      if (num != 4'd0 && k == total) begin
        finished = 1'b1;
        break;
      end
      check("sel", 32'(bus.sel), 32'((k / HP) % 2));
      check("busy", 32'(bus.busy), 32'd1);
      check("done_mid", 32'(bus.done), 32'd0);
      check("rdy_busy", 32'(bus.in_ready), 32'd0);
      check("seg_hold", 32'(bus.seg_data), 32'(seg_exp));
      if (pend_en && k == 2) begin
        bus.in_valid = 1'b1;
        bus.in_data  = pend_dig;
      end
      bus.blink_start = (k == restart_at);
      @(negedge clk);
    end
    bus.blink_start = 1'b0;
    check("seq_bounded", 32'(finished), 32'd1);
    check("end_busy", 32'(bus.busy), 32'd0);
    check("end_sel", 32'(bus.sel), 32'd0);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("end_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("done_once", 32'(bus.done), 32'd0);
    check("idle_sel", 32'(bus.sel), 32'd0);
    if (pend_en) begin
      check("pend_load", 32'(bus.seg_data), 32'(seg_tab[pend_dig]));
      bus.in_valid = 1'b0;
    end else begin
      check("seg_after", 32'(bus.seg_data), 32'(seg_exp));
    end
  endtask

  initial begin
    logic [3:0] dig;
    logic [3:0] num;
    int         stop_at;
    int         restart_at;

    n_run  = 0;
    n_fail = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 4'h0;
    bus.blink_start = 1'b0;
    bus.blink_num   = 4'h0;
    bus.blink_stop  = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_rdy", 32'(bus.in_ready), 32'd1);
    check("rst_seg", 32'(bus.seg_data), 32'h3F);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("blank_pat", 32'(bus.seg_blank), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 32'(bus.in_ready), 32'd1);

    // Load digit 7
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h7;
    check("rdy_load", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("seg_7", 32'(bus.seg_data), 32'h07);
    check("load_sel", 32'(bus.sel), 32'd0);
    check("load_busy", 32'(bus.busy), 32'd0);

    // Two blinks, with an ignored start request in the middle
    blink_run(4'd2, -1, 5, 7'h07, 1'b0, 4'h0);

    // Stop in IDLE is ignored
    bus.blink_stop = 1'b1;
    @(negedge clk);
    bus.blink_stop = 1'b0;
    check("idle_stop_done", 32'(bus.done), 32'd0);
    check("idle_stop_busy", 32'(bus.busy), 32'd0);

    // Endless blinking aborted 10 cycles in, then no further toggling
    blink_run(4'd0, 10, -1, 7'h07, 1'b0, 4'h0);
    repeat (12) begin
      @(negedge clk);
      check("quiet_sel", 32'(bus.sel), 32'd0);
      check("quiet_busy", 32'(bus.busy), 32'd0);
      check("quiet_done", 32'(bus.done), 32'd0);
    end

    // Digit load held off during blinking, taken on the first IDLE cycle
    blink_run(4'd1, -1, -1, 7'h07, 1'b1, 4'hA);

    // Start and stop together in IDLE: nothing happens
    bus.blink_num   = 4'd3;
    bus.blink_start = 1'b1;
    bus.blink_stop  = 1'b1;
    @(negedge clk);
    bus.blink_start = 1'b0;
    bus.blink_stop  = 1'b0;
    check("ss_busy", 32'(bus.busy), 32'd0);
    check("ss_done", 32'(bus.done), 32'd0);
    check("ss_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("ss_busy2", 32'(bus.busy), 32'd0);
    check("ss_done2", 32'(bus.done), 32'd0);

    // Load 0xE together with the start: first ON phase already shows it
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hE;
    blink_run(4'd1, -1, -1, 7'h79, 1'b0, 4'h0);

    // Reset pulse during OFF: immediate clear, no done, normal resume
    bus.blink_num   = 4'd2;
    bus.blink_start = 1'b1;
    @(negedge clk);
    bus.blink_start = 1'b0;
    repeat (HP + 1) @(negedge clk);
    check("pre_rst_sel", 32'(bus.sel), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(bus.sel), 32'd0);
    check("arst_seg", 32'(bus.seg_data), 32'h3F);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("arst_no_done", 32'(bus.done), 32'd0);
      check("arst_idle", 32'(bus.busy), 32'd0);
    end
    blink_run(4'd1, -1, -1, 7'h3F, 1'b0, 4'h0);

    // Randomized sequences: digit loaded with the start, random count, optional abort
    repeat (8) begin
      dig = 4'($urandom_range(0, 15));
      num = 4'($urandom_range(0, 3));
      if (num == 4'd0)
        stop_at = int'($urandom_range(0, 30));
      else if ($urandom_range(0, 1) == 1)
        stop_at = int'($urandom_range(0, 2 * HP * int'(num) - 1));
      else
        stop_at = -1;
      restart_at = int'($urandom_range(0, 9));
      bus.in_valid = 1'b1;
      bus.in_data  = dig;
      blink_run(num, stop_at, restart_at, seg_tab[dig], 1'b0, 4'h0);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_blink_driver.md
SEG7_BLINK_DRIVER -- requirements
Module: seg7_blink_driver

Parameters
REQ-001 SHALL have parameter HALF_PERIOD, default 25000000, meaning clock cycles per blink half-phase (0.5 s at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter CNT_W, default 25, meaning phase-counter width; SHALL satisfy 2^CNT_W >= HALF_PERIOD.
REQ-003 SHALL have parameter BLANK_PAT, default 7'h00, meaning the 7-bit pattern shown during the blink off-phase.

Interface
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  digit-load request.
REQ-007 in_ready  out  1  digit-load accept.
REQ-008 in_data  in  4  hex digit 0x0..0xF.
REQ-009 blink_start  in  1  single-cycle request to start blinking.
REQ-010 blink_num  in  4  number of blinks; 0 = blink until stopped.
REQ-011 blink_stop  in  1  single-cycle request to abort blinking.
REQ-012 seg_data  out  7  decoded pattern; feeds the downstream 2:1 mux input 0.
REQ-013 seg_blank  out  7  constant BLANK_PAT; feeds mux input 1.
REQ-014 sel  out  1  mux select; 0 = show seg_data, 1 = show blank.
REQ-015 busy  out  1  high in ON or OFF states.
REQ-016 done  out  1  one-cycle pulse when blinking ends.

Function
REQ-017 SHALL transfer a digit when in_valid && in_ready are high on a rising edge; in_ready = 1 in IDLE only, 0 in ON/OFF.
REQ-018 SHALL register seg_data; it SHALL reflect the accepted digit on the cycle after acceptance.
REQ-019 Decode SHALL be active-high, bit0=a..bit6=g: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 The FSM SHALL have states IDLE (sel=0), ON (sel=0), and OFF (sel=1); sel SHALL be registered and decoded from the state.
REQ-021 In IDLE, blink_start=1 with blink_stop=0 SHALL:
- latch blink_num into a remaining counter;
- clear the phase counter;
- enter ON next cycle.
REQ-022 The phase counter SHALL count 0..HALF_PERIOD-1 in ON and in OFF; each state SHALL last exactly HALF_PERIOD cycles.
REQ-023 At the terminal count in ON, the FSM SHALL go to OFF and clear the counter.
REQ-024 At the terminal count in OFF, the FSM SHALL decrement the remaining counter:
- if the result is 0 and blink_num was nonzero, go to IDLE and pulse done;
- otherwise go to ON.
REQ-025 With blink_num=0, the FSM SHALL alternate ON/OFF indefinitely; the remaining counter SHALL NOT wrap.
REQ-026 blink_stop in ON or OFF SHALL force IDLE, sel=0, and a done pulse on the next cycle, regardless of counter value.
REQ-027 blink_start while busy SHALL be ignored; blink_stop in IDLE SHALL be ignored (no done).
REQ-028 blink_start and blink_stop together in IDLE: stop SHALL win, so the FSM stays in IDLE.
REQ-029 in_valid and blink_start together in IDLE: the digit SHALL be loaded and blinking SHALL start; the first ON phase SHALL show the new digit.
REQ-030 in_valid while busy SHALL be held off (in_ready=0); seg_data SHALL stay unchanged until IDLE.
REQ-031 done SHALL be high for exactly one cycle per completed or aborted blink sequence.

Reset
REQ-032 rst_n=0 SHALL immediately (asynchronously) force:
- state IDLE, digit 0, seg_data=7'h3F;
- sel=0, busy=0, done=0;
- phase counter 0, remaining 0.
REQ-033 in_ready SHALL read 1 while in reset and after release.
REQ-034 Reset asserted mid-blink SHALL abort with no done pulse; operation SHALL resume normally after release.

Verification (HALF_PERIOD=4)
REQ-035 Reset, then load in_data=0x7 -> in_ready=1 during load, seg_data=7'h07 next cycle, sel=0, busy=0.
REQ-036 blink_num=2 with blink_start -> sel pattern 0000 1111 0000 1111; then IDLE, done high for 1 cycle, 16 busy cycles total.
REQ-037 blink_num=0 with blink_start, blink_stop 10 cycles later -> sel=0, busy=0, done pulse the next cycle; no further toggling.
REQ-038 in_valid=1 with in_data=0xA during blinking -> in_ready=0, seg_data unchanged; the digit is accepted on the first IDLE cycle and seg_data becomes 7'h77.
REQ-039 blink_start and blink_stop in the same IDLE cycle -> no state change, no done; in_valid and blink_start together with 0xE -> ON phase shows 7'h79.
REQ-040 rst_n pulsed low during OFF -> sel=0 and seg_data=7'h3F immediately, no done pulse.
